// File: rtl/go_sequencer.sv
// Steps through up to three go/kill/done delay channels in fixed order. Each channel
// is issued a go pulse and is killed if it does not report done within TIMEOUT cycles.
module go_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [2:0] i_chan_en,
    input  logic       i_abort,
    input  logic       i_done_1,
    input  logic       i_done_2,
    input  logic       i_done_3,
    input  logic       i_kill_ltchd,
    output logic       o_go_1,
    output logic       o_go_2,
    output logic       o_go_3,
    output logic       o_kill_1,
    output logic       o_kill_2,
    output logic       o_kill_3,
    output logic       o_kill_clr,
    output logic       o_busy,
    output logic       o_seq_done,
    output logic       o_seq_err,
    output logic [2:0] o_chan_ok
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_KILL,
        S_CLEAR,
        S_FINISH
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [2:0] r_pend;
    logic [2:0] r_sel;
    logic [7:0] r_timer;
    logic       r_err;
    logic [2:0] r_go;
    logic [2:0] r_kill;
    logic       r_kill_clr;
    logic       r_busy;
    logic       r_seq_done;
    logic       r_seq_err;
    logic [2:0] r_chan_ok;

    logic [2:0] w_done;
    logic       w_sel_done;

    // Isolates the lowest set bit, which gives the 1 -> 2 -> 3 service order.
    function automatic logic [2:0] lowest_bit(input logic [2:0] v);
        return v & (~v + 3'd1);
    endfunction

    assign w_done     = {i_done_3, i_done_2, i_done_1};
    assign w_sel_done = |(w_done & r_sel);

    // NOTE: every register, including the pending mask and timer, is cleared by the
    // async reset so a reset mid-sequence leaves no stale channel behind; all state
    // updates use non-blocking assignments so the case arms read pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_pend     <= '0;
            r_sel      <= '0;
            r_timer    <= '0;
            r_err      <= 1'b0;
            r_go       <= '0;
            r_kill     <= '0;
            r_kill_clr <= 1'b0;
            r_busy     <= 1'b0;
            r_seq_done <= 1'b0;
            r_seq_err  <= 1'b0;
            r_chan_ok  <= '0;
        end else begin
            r_go       <= '0;
            r_kill     <= '0;
            r_kill_clr <= 1'b0;
            r_seq_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pend    <= i_chan_en;
                        r_chan_ok <= '0;
                        r_seq_err <= 1'b0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        if (i_chan_en != 3'b000) begin
                            r_sel   <= lowest_bit(i_chan_en);
                            r_go    <= lowest_bit(i_chan_en);
                            r_state <= S_ISSUE;
                        end else begin
                            r_seq_done <= 1'b1;
                            r_state    <= S_FINISH;
                        end
                    end
                end

                S_ISSUE: begin
                    r_timer <= '0;
                    if (i_abort) begin
                        r_pend  <= '0;
                        r_kill  <= r_sel;
                        r_state <= S_KILL;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (i_abort) begin
                        r_pend  <= '0;
                        r_kill  <= r_sel;
                        r_state <= S_KILL;
                    end else if (w_sel_done) begin
                        r_pend    <= r_pend & ~r_sel;
                        r_chan_ok <= r_chan_ok | r_sel;
                        r_state   <= S_NEXT;
                    end else if (r_timer == TIMER_LAST) begin
                        r_kill  <= r_sel;
                        r_state <= S_KILL;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                S_KILL: begin
                    r_pend  <= r_pend & ~r_sel;
                    r_err   <= 1'b1;
                    r_state <= S_CLEAR;
                end

                S_CLEAR: begin
                    // Hold here until the downstream latch reports cleared.
                    r_kill_clr <= i_kill_ltchd;
                    if (i_abort) begin
                        r_pend <= '0;
                    end
                    if (!i_kill_ltchd) begin
                        r_state <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (i_abort || r_pend == 3'b000) begin
                        r_pend     <= '0;
                        r_seq_done <= 1'b1;
                        r_state    <= S_FINISH;
                    end else begin
                        r_sel   <= lowest_bit(r_pend);
                        r_go    <= lowest_bit(r_pend);
                        r_state <= S_ISSUE;
                    end
                end

                S_FINISH: begin
                    r_seq_err <= r_err;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_go_1     = r_go[0];
    assign o_go_2     = r_go[1];
    assign o_go_3     = r_go[2];
    assign o_kill_1   = r_kill[0];
    assign o_kill_2   = r_kill[1];
    assign o_kill_3   = r_kill[2];
    assign o_kill_clr = r_kill_clr;
    assign o_busy     = r_busy;
    assign o_seq_done = r_seq_done;
    assign o_seq_err  = r_seq_err;
    assign o_chan_ok  = r_chan_ok;

endmodule

// File: tb/tb_go_sequencer.sv
// Directed bench for go_sequencer: a reactive downstream model answers go pulses with
// done after a chosen delay, and each scenario task compares the recorded trace.
module tb_go_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] chan_en;
    logic       abort;
    logic [2:0] done_v;
    logic       kill_ltchd;
    logic       go_1, go_2, go_3;
    logic       kill_1, kill_2, kill_3;
    logic       kill_clr;
    logic       busy;
    logic       seq_done;
    logic       seq_err;
    logic [2:0] chan_ok;

    int n_checks;
    int n_errors;

    // Trace of the most recent sequence, in cycles counted from the start pulse.
    int         go_cyc[3];
    int         kill_cyc[3];
    int         go_cnt;
    int         kill_cnt;
    int         clr_cnt;
    int         overlap;
    int         done_cyc;
    logic       err_after;
    logic [2:0] ok_after;
    logic       busy_after;

    go_sequencer #(.TIMEOUT(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_chan_en    (chan_en),
        .i_abort      (abort),
        .i_done_1     (done_v[0]),
        .i_done_2     (done_v[1]),
        .i_done_3     (done_v[2]),
        .i_kill_ltchd (kill_ltchd),
        .o_go_1       (go_1),
        .o_go_2       (go_2),
        .o_go_3       (go_3),
        .o_kill_1     (kill_1),
        .o_kill_2     (kill_2),
        .o_kill_3     (kill_3),
        .o_kill_clr   (kill_clr),
        .o_busy       (busy),
        .o_seq_done   (seq_done),
        .o_seq_err    (seq_err),
        .o_chan_ok    (chan_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one sequence. d1..d3: cycles after go_n at which done_n pulses (-1 = never).
    // stray: done bits held high throughout. lat_react: emulate the downstream kill latch.
    task automatic run_seq(input logic [2:0] en, input int d1, input int d2, input int d3,
                           input int abort_at, input int restart_at, input bit lat_react,
                           input logic [2:0] stray);
        int         d[3];
        int         cyc;
        bit         lat;
        bit         finished;
        logic [2:0] go_w;
        logic [2:0] kill_w;
        d[0] = d1; d[1] = d2; d[2] = d3;
        for (int n = 0; n < 3; n++) begin
            go_cyc[n]   = -1;
            kill_cyc[n] = -1;
        end
        go_cnt = 0; kill_cnt = 0; clr_cnt = 0; overlap = 0; done_cyc = -1;
        lat = 1'b0;
        finished = 1'b0;
        chan_en = en;
        start   = 1'b1;
        done_v  = stray;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!finished && cyc < 200) begin
            go_w   = {go_3, go_2, go_1};
            kill_w = {kill_3, kill_2, kill_1};
            for (int n = 0; n < 3; n++) begin
                if (go_w[n])   begin go_cyc[n] = cyc;   go_cnt++;   end
                if (kill_w[n]) begin kill_cyc[n] = cyc; kill_cnt++; end
            end
            if ($countones({go_w, kill_w}) > 1) overlap++;
            if (kill_clr) clr_cnt++;
            if (seq_done) begin
                done_cyc = cyc;
                finished = 1'b1;
            end
            for (int n = 0; n < 3; n++) begin
                done_v[n] = stray[n] | (go_cyc[n] >= 0 && d[n] >= 0 && cyc == go_cyc[n] + d[n]);
            end
            abort      = (cyc == abort_at);
            start      = (cyc == restart_at);
            chan_en    = (cyc == restart_at) ? 3'b000 : en;
            kill_ltchd = lat;
            if (lat_react && |kill_w) lat = 1'b1;
            if (kill_clr)             lat = 1'b0;
            tick();
            cyc++;
        end
        done_v = '0; abort = 1'b0; start = 1'b0; kill_ltchd = 1'b0;
        err_after  = seq_err;
        ok_after   = chan_ok;
        busy_after = busy;
    endtask

    task automatic test_reset();
        logic [14:0] outs;
        rst_n = 1'b0;
        start = 1'b0; chan_en = '0; abort = 1'b0; done_v = '0; kill_ltchd = 1'b0;
        #3;
        outs = {go_1, go_2, go_3, kill_1, kill_2, kill_3, kill_clr, busy, seq_done, seq_err, chan_ok, 2'b00};
        n_checks++;
        if (outs !== 15'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b, expected all zero", outs);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_channels();
        run_seq(3'b111, 3, 3, 3, -1, 7, 1'b0, 3'b000);
        n_checks++;
        if (go_cyc[0] !== 1 || go_cyc[1] !== 6 || go_cyc[2] !== 11) begin
            n_errors++;
            $display("FAIL all_go_order: got %0d/%0d/%0d, expected 1/6/11", go_cyc[0], go_cyc[1], go_cyc[2]);
        end
        n_checks++;
        if (done_cyc !== 16) begin
            n_errors++;
            $display("FAIL all_seq_done: got cycle %0d, expected 16", done_cyc);
        end
        n_checks++;
        if (ok_after !== 3'b111 || err_after !== 1'b0) begin
            n_errors++;
            $display("FAIL all_status: got chan_ok=%b err=%b, expected 111 0", ok_after, err_after);
        end
        n_checks++;
        if (go_cnt !== 3 || kill_cnt !== 0 || overlap !== 0) begin
            n_errors++;
            $display("FAIL all_pulses: got go=%0d kill=%0d overlap=%0d, expected 3 0 0", go_cnt, kill_cnt, overlap);
        end
        n_checks++;
        if (busy_after !== 1'b0) begin
            n_errors++;
            $display("FAIL all_busy_after: got %b, expected 0", busy_after);
        end
    endtask

    task automatic test_timeout();
        run_seq(3'b010, -1, -1, -1, -1, -1, 1'b1, 3'b101);
        n_checks++;
        if (go_cyc[1] !== 1 || kill_cyc[1] !== 18) begin
            n_errors++;
            $display("FAIL timeout_kill: got go_2@%0d kill_2@%0d, expected 1 18", go_cyc[1], kill_cyc[1]);
        end
        n_checks++;
        if (clr_cnt !== 2) begin
            n_errors++;
            $display("FAIL timeout_kill_clr: got %0d cycles, expected 2", clr_cnt);
        end
        n_checks++;
        if (done_cyc !== 23) begin
            n_errors++;
            $display("FAIL timeout_seq_done: got cycle %0d, expected 23", done_cyc);
        end
        n_checks++;
        if (err_after !== 1'b1 || ok_after !== 3'b000) begin
            n_errors++;
            $display("FAIL timeout_status: got err=%b chan_ok=%b, expected 1 000", err_after, ok_after);
        end
        n_checks++;
        if (go_cnt !== 1 || kill_cnt !== 1 || overlap !== 0) begin
            n_errors++;
            $display("FAIL timeout_pulses: got go=%0d kill=%0d overlap=%0d, expected 1 1 0", go_cnt, kill_cnt, overlap);
        end
    endtask

    task automatic test_done_at_limit();
        run_seq(3'b101, 16, -1, 2, -1, -1, 1'b0, 3'b000);
        n_checks++;
        if (kill_cnt !== 0) begin
            n_errors++;
            $display("FAIL limit_no_kill: got %0d kills, expected 0", kill_cnt);
        end
        n_checks++;
        if (go_cyc[2] !== 19 || go_cyc[1] !== -1) begin
            n_errors++;
            $display("FAIL limit_go3: got go_3@%0d go_2@%0d, expected 19 -1", go_cyc[2], go_cyc[1]);
        end
        n_checks++;
        if (ok_after !== 3'b101 || err_after !== 1'b0 || done_cyc !== 23) begin
            n_errors++;
            $display("FAIL limit_status: got chan_ok=%b err=%b done@%0d, expected 101 0 23", ok_after, err_after, done_cyc);
        end
    endtask

    task automatic test_done_in_issue();
        run_seq(3'b001, 0, -1, -1, -1, -1, 1'b0, 3'b000);
        n_checks++;
        if (kill_cyc[0] !== 18 || done_cyc !== 21) begin
            n_errors++;
            $display("FAIL issue_done_ignored: got kill_1@%0d done@%0d, expected 18 21", kill_cyc[0], done_cyc);
        end
        n_checks++;
        if (ok_after !== 3'b000 || err_after !== 1'b1) begin
            n_errors++;
            $display("FAIL issue_status: got chan_ok=%b err=%b, expected 000 1", ok_after, err_after);
        end
    endtask

    task automatic test_empty();
        run_seq(3'b000, -1, -1, -1, -1, -1, 1'b0, 3'b000);
        n_checks++;
        if (done_cyc !== 1 || go_cnt !== 0) begin
            n_errors++;
            $display("FAIL empty_seq: got done@%0d go=%0d, expected 1 0", done_cyc, go_cnt);
        end
        n_checks++;
        if (err_after !== 1'b0 || ok_after !== 3'b000) begin
            n_errors++;
            $display("FAIL empty_status: got err=%b chan_ok=%b, expected 0 000", err_after, ok_after);
        end
    endtask

    task automatic test_abort();
        run_seq(3'b111, -1, -1, -1, 3, -1, 1'b0, 3'b000);
        n_checks++;
        if (kill_cyc[0] !== 4 || go_cnt !== 1 || kill_cnt !== 1) begin
            n_errors++;
            $display("FAIL abort_pulses: got kill_1@%0d go=%0d kill=%0d, expected 4 1 1", kill_cyc[0], go_cnt, kill_cnt);
        end
        n_checks++;
        if (done_cyc !== 7 || err_after !== 1'b1 || ok_after !== 3'b000) begin
            n_errors++;
            $display("FAIL abort_status: got done@%0d err=%b chan_ok=%b, expected 7 1 000", done_cyc, err_after, ok_after);
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] outs;
        int          stray_done;
        chan_en = 3'b111;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        outs = {go_1, go_2, go_3, kill_1, kill_2, kill_3, kill_clr, busy, seq_done, seq_err, chan_ok, 2'b00};
        n_checks++;
        if (outs !== 15'd0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: got %b, expected all zero", outs);
        end
        stray_done = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (seq_done) stray_done++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (seq_done || busy) stray_done++;
        end
        n_checks++;
        if (stray_done !== 0) begin
            n_errors++;
            $display("FAIL mid_reset_quiet: got %0d active cycles, expected 0", stray_done);
        end
        run_seq(3'b111, 3, 3, 3, -1, -1, 1'b0, 3'b000);
        n_checks++;
        if (done_cyc !== 16 || ok_after !== 3'b111 || err_after !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_rerun: got done@%0d chan_ok=%b err=%b, expected 16 111 0", done_cyc, ok_after, err_after);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_all_channels();
        test_timeout();
        test_done_at_limit();
        test_done_in_issue();
        test_empty();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
